if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction fetch stage sitting between the instruction ROM and the IF/ID pipeline register.
//  Owns the PC and issues pipelined ROM reads over a request/grant/rvalid handshake.
//  Buffers returned words with their PCs in a small prefetch FIFO.
//  Absorbs downstream stalls and branch redirects, and drops in-flight fetches after a redirect.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of first fetch after reset; word aligned
//  FIFO_DEPTH  2              prefetch entries; power of 2, range 2..8; also the max number of in-flight reads
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   asynchronous, active-low reset
//  stall_i          in   1   downstream (IF/ID) cannot accept this cycle
//  branch_flag_i    in   1   redirect fetch this cycle
//  branch_target_i  in   32  redirect PC; bits[1:0] ignored (forced 0)
//  rom_ce_o         out  1   read request valid
//  rom_addr_o       out  32  read address (= pc_q)
//  rom_gnt_i        in   1   ROM accepts request this cycle
//  rom_rvalid_i     in   1   read data valid; responses in request order
//  rom_data_i       in   32  read data
//  if_valid_o       out  1   if_pc_o/if_inst_o hold a valid instruction
//  if_pc_o          out  32  PC of head instruction
//  if_inst_o        out  32  head instruction word
// BEHAVIOUR
//  Reset (rst=0, async):
//   - pc_q=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
//   - rom_ce_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
//  Issue:
//   - rom_ce_o=1 iff !branch_flag_i && (fifo_cnt+outstanding) < FIFO_DEPTH.
//   - Handshake completes on rom_ce_o&&rom_gnt_i: pc_q+=4 (mod 2^32), pc_q is pushed to a tag queue,
//     outstanding++.
//   - rom_addr_o is stable while rom_ce_o=1 and ungranted.
//  Response:
//   - rvalid may not arrive before the cycle after the grant; at most 1 per cycle.
//   - If drop_cnt>0: word discarded, drop_cnt--, outstanding--.
//   - Otherwise {tag head, rom_data_i} is written into the FIFO, the tag is popped and outstanding--.
//   - rvalid with outstanding=0 is ignored; no state change.
//  Output:
//   - Registered FIFO head with no bypass. if_valid_o = !fifo_empty.
//   - Pop when if_valid_o && !stall_i && !branch_flag_i.
//   - Minimum latency: grant in cycle t, rvalid in t+1, if_valid_o=1 in t+2.
//   - Push and pop in the same cycle are both performed.
//   - Overflow cannot occur by the credit rule.
//  Redirect (branch_flag_i=1 in cycle t), at edge t:
//   - FIFO flushed; pc_q = {branch_target_i[31:2],2'b0}.
//   - drop_cnt = outstanding minus any rvalid consumed in cycle t; tag queue cleared.
//   - Requests resume at t+1 even while drops are pending (credit still counts outstanding).
//  Simultaneous events:
//   - Branch overrides stall and pop.
//   - A redirect during pending drops adds the new outstanding count to drop_cnt.
//   - pc_q wrap 32'hFFFF_FFFC -> 0 is silent.
//  Reset mid-operation: all state returns to reset values immediately; later rvalid is ignored.
// TESTING
//  1. Reset, ROM always grants, 1-cycle rvalid -> addrs 0,4,8..; first if_valid_o 2 cycles after first grant;
//     PCs consecutive.
//  2. stall_i=1 for 5 cycles with DEPTH=2 -> rom_ce_o drops after 2 in flight; no lost or duplicated PC;
//     order kept on release.
//  3. branch_flag_i with target 32'h0000_0103 while 2 reads are in flight -> both responses dropped;
//     next if_pc_o=32'h100.
//  4. rom_gnt_i held low 3 cycles -> rom_addr_o constant; pc_q advances only on grant.
//  5. Branch and stall in the same cycle with a full FIFO -> FIFO flushed, if_valid_o=0 next cycle.
//  6. RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; rst pulse mid-stream -> outputs 0,
//     restart at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage between the instruction ROM and the IF/ID register.
//   Owns the PC and issues pipelined ROM reads over a request/grant/rvalid
//   handshake. Returned words are paired with their PCs and held in a small
//   prefetch FIFO. Downstream stalls and branch redirects are absorbed here.
//   Reads still in flight at a redirect are discarded as they return.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset (word aligned)
//   FIFO_DEPTH  prefetch entries and max in-flight reads (power of 2, 2..8)
//
// Ports
//   clk              clock, rising edge
//   rst              asynchronous reset, active low
//   stall_i          IF/ID cannot accept an instruction this cycle
//   branch_flag_i    redirect fetch this cycle
//   branch_target_i  redirect PC (bits [1:0] ignored)
//   rom_ce_o         read request valid
//   rom_addr_o       read address (current PC)
//   rom_gnt_i        ROM accepts the request this cycle
//   rom_rvalid_i     read data valid, responses in request order
//   rom_data_i       read data
//   if_valid_o       if_pc_o / if_inst_o hold a valid instruction
//   if_pc_o          PC of the head instruction
//   if_inst_o        head instruction word
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    // Control state
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [CW-1:0] out_q, out_d;     // reads granted but not yet returned
    logic [CW-1:0] drop_q, drop_d;   // returns still to be discarded

    // Storage
    logic [31:0] fifo_pc_q   [0:FIFO_DEPTH-1];
    logic [31:0] fifo_inst_q [0:FIFO_DEPTH-1];
    logic [31:0] tag_q       [0:FIFO_DEPTH-1];

    logic [CW:0] in_use;
    logic        credit_ok;
    logic        issue;
    logic        rsp;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        fifo_push;
    logic        pop;

    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^branch_target_i[1:0];

    // Credits cover both buffered words and every read still in flight,
    // including the ones that will be dropped, so the FIFO can never overflow.
    assign in_use    = {1'b0, fifo_cnt_q} + {1'b0, out_q};
    assign credit_ok = in_use < DEPTH_C;

    // Gating with rst keeps the request low while reset is held.
    assign rom_ce_o   = rst & ~branch_flag_i & credit_ok;
    assign rom_addr_o = pc_q;
    assign issue      = rom_ce_o & rom_gnt_i;

    // A return with nothing outstanding is stray and ignored.
    assign rsp       = rom_rvalid_i & (out_q != '0);
    assign rsp_drop  = rsp & (drop_q != '0);
    assign rsp_keep  = rsp & (drop_q == '0);
    assign fifo_push = rsp_keep & ~branch_flag_i;

    assign if_valid_o = (fifo_cnt_q != '0);
    assign pop        = if_valid_o & ~stall_i & ~branch_flag_i;
    assign if_pc_o    = if_valid_o ? fifo_pc_q[fifo_rd_q]   : '0;
    assign if_inst_o  = if_valid_o ? fifo_inst_q[fifo_rd_q] : '0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pc_d       = pc_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        drop_d     = drop_q;
        out_d      = out_q + CW'(issue) - CW'(rsp);

        if (branch_flag_i) begin
            // Everything already requested becomes a drop; a word returning
            // in this very cycle is consumed by the flush instead.
            pc_d       = {branch_target_i[31:2], 2'b00};
            drop_d     = out_q - CW'(rsp);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
        end else begin
            if (issue)     pc_d      = pc_q + 32'd4;
            if (issue)     tag_wr_d  = tag_wr_q + AW'(1);
            if (rsp_keep)  tag_rd_d  = tag_rd_q + AW'(1);
            if (fifo_push) fifo_wr_d = fifo_wr_q + AW'(1);
            if (pop)       fifo_rd_d = fifo_rd_q + AW'(1);
            fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(pop);
            drop_d     = drop_q - CW'(rsp_drop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: storage arrays are not reset; the counts and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_q[tag_wr_q] <= pc_q;
        end
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
            fifo_inst_q[fifo_wr_q] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A ROM model answers granted reads in
//   order after a programmable latency; each granted read pushes its expected
//   {pc, inst} into a scoreboard queue which is compared against the head the
//   DUT presents. Redirects clear the scoreboard and turn in-flight reads into
//   expected drops. RESET_PC sits near the top of the address space so the PC
//   wrap is exercised from the first fetches.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    typedef struct {
        logic [31:0] addr;
        int          rdy;
    } rom_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i = 1'b0;
    logic        rom_rvalid_i = 1'b0;
    logic [31:0] rom_data_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_ce_o       (rom_ce_o),
        .rom_addr_o     (rom_addr_o),
        .rom_gnt_i      (rom_gnt_i),
        .rom_rvalid_i   (rom_rvalid_i),
        .rom_data_i     (rom_data_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o)
    );

    always #5 clk = ~clk;

    // Scoreboard and ROM model state
    sb_t         sb[$];
    rom_t        rom_pend[$];
    logic [31:0] grant_log[$];
    int          model_drop;
    logic [31:0] exp_pc;
    int          cyc;
    int          n_tests;
    int          n_fail;

    // Stimulus knobs
    bit          gnt_v, stall_v, br_v, rnd_v, inject_v;
    logic [31:0] tgt_v;
    int          lat_v;

    // Observations from the last cycle
    logic        last_ce, last_valid;
    logic [31:0] last_addr, last_pop_pc;
    bit          saw_pop;
    int          first_grant, first_valid;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_5A17;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs 1ns
    // later, then advance the model by what the next rising edge will do.
    task automatic cycle();
        bit   rsp, drop_now, grant, pop, exp_ce;
        rom_t r;
        sb_t  e;
        @(negedge clk);
        cyc++;
        if (rnd_v) begin
            gnt_v   = ($urandom_range(0, 3) != 0);
            stall_v = ($urandom_range(0, 3) == 0);
            br_v    = ($urandom_range(0, 24) == 0);
            tgt_v   = $urandom();
            lat_v   = $urandom_range(1, 3);
        end
        rsp          = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_data_i   = '0;
        if (inject_v) begin
            rom_rvalid_i = 1'b1;
            rom_data_i   = 32'hDEAD_BEEF;
            inject_v     = 1'b0;
        end else if (rom_pend.size() != 0 && rom_pend[0].rdy <= cyc) begin
            r            = rom_pend.pop_front();
            rom_rvalid_i = 1'b1;
            rom_data_i   = data_fn(r.addr);
            rsp          = 1'b1;
        end
        drop_now        = rsp && (model_drop > 0);
        stall_i         = stall_v;
        branch_flag_i   = br_v;
        branch_target_i = tgt_v;
        rom_gnt_i       = gnt_v;
        #1;
        exp_ce = !br_v && ((sb.size() + model_drop) < DEPTH);
        check("rom_ce", 32'(rom_ce_o), 32'(exp_ce));
        last_ce    = rom_ce_o;
        last_valid = if_valid_o;
        last_addr  = rom_addr_o;
        grant      = rom_ce_o && gnt_v;
        if (rom_ce_o) check("rom_addr", rom_addr_o, exp_pc);
        if (if_valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(if_valid_o), 32'd0);
            end else begin
                check("if_pc", if_pc_o, sb[0].pc);
                check("if_inst", if_inst_o, sb[0].inst);
            end
        end
        pop = if_valid_o && !stall_v && !br_v;
        if (grant) grant_log.push_back(rom_addr_o);
        if (grant && first_grant < 0) first_grant = cyc;
        if (if_valid_o && first_valid < 0) first_valid = cyc;
        if (drop_now) model_drop--;
        if (pop) begin
            last_pop_pc = if_pc_o;
            saw_pop     = 1'b1;
            if (sb.size() != 0) sb.delete(0);
        end
        if (br_v) begin
            sb.delete();
            model_drop = rom_pend.size();
            exp_pc     = {tgt_v[31:2], 2'b00};
        end else if (grant) begin
            e.pc   = exp_pc;
            e.inst = data_fn(exp_pc);
            sb.push_back(e);
            r.addr = exp_pc;
            r.rdy  = cyc + lat_v;
            rom_pend.push_back(r);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        rom_gnt_i     = 1'b0;
        rom_rvalid_i  = 1'b0;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        #1;
        check("rst_rom_ce", 32'(rom_ce_o), 32'd0);
        check("rst_if_valid", 32'(if_valid_o), 32'd0);
        check("rst_if_pc", if_pc_o, 32'd0);
        check("rst_if_inst", if_inst_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        rom_pend.delete();
        model_drop = 0;
        exp_pc     = RESET_PC;
    endtask

    // Stop requesting and let every outstanding word come out.
    task automatic drain();
        gnt_v   = 1'b0;
        stall_v = 1'b0;
        br_v    = 1'b0;
        for (int i = 0; i < 40 && (sb.size() != 0 || rom_pend.size() != 0); i++) cycle();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a0, v;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        model_drop  = 0;
        exp_pc      = RESET_PC;
        first_grant = -1;
        first_valid = -1;
        gnt_v       = 1'b1;
        stall_v     = 1'b0;
        br_v        = 1'b0;
        rnd_v       = 1'b0;
        inject_v    = 1'b0;
        tgt_v       = '0;
        lat_v       = 1;
        last_pop_pc = '0;
        saw_pop     = 1'b0;

        // Reset, always-grant ROM, single-cycle returns, PC wrap
        do_reset();
        gnt_v = 1'b1;
        repeat (10) cycle();
        check("first_valid_latency", 32'(first_valid), 32'(first_grant + 2));
        check("wrap_addr0", grant_log[0], 32'hFFFF_FFF8);
        check("wrap_addr1", grant_log[1], 32'hFFFF_FFFC);
        check("wrap_addr2", grant_log[2], 32'h0000_0000);

        // Stall for 5 cycles: requests stop once the credits are used
        stall_v = 1'b1;
        repeat (5) cycle();
        check("stall_ce_off", 32'(last_ce), 32'd0);
        check("stall_valid_held", 32'(last_valid), 32'd1);
        stall_v = 1'b0;
        repeat (8) cycle();

        // Redirect with two reads in flight: both returns dropped
        drain();
        gnt_v = 1'b1;
        lat_v = 3;
        for (int i = 0; i < 10 && rom_pend.size() < 2; i++) cycle();
        br_v  = 1'b1;
        tgt_v = 32'h0000_0103;
        cycle();
        br_v    = 1'b0;
        lat_v   = 1;
        saw_pop = 1'b0;
        last_pop_pc = '0;
        for (int i = 0; i < 20 && !saw_pop; i++) cycle();
        check("branch_target_pc", last_pop_pc, 32'h0000_0100);

        // Grant withheld: address holds, PC moves only on grant
        drain();
        gnt_v = 1'b0;
        cycle();
        a0 = last_addr;
        check("nogrant_ce", 32'(last_ce), 32'd1);
        repeat (2) begin
            cycle();
            check("addr_hold", last_addr, a0);
        end
        gnt_v = 1'b1;
        cycle();
        gnt_v = 1'b0;
        cycle();
        check("addr_after_grant", last_addr, a0 + 32'd4);

        // Branch and stall together with a full FIFO
        stall_v = 1'b1;
        gnt_v   = 1'b1;
        lat_v   = 1;
        repeat (6) cycle();
        check("fifo_full_valid", 32'(last_valid), 32'd1);
        br_v  = 1'b1;
        tgt_v = 32'h0000_0200;
        cycle();
        br_v  = 1'b0;
        gnt_v = 1'b0;
        cycle();
        check("flush_valid", 32'(last_valid), 32'd0);
        stall_v = 1'b0;
        gnt_v   = 1'b1;
        repeat (6) cycle();

        // Reset mid-stream, stray return afterwards, restart at RESET_PC
        lat_v = 2;
        repeat (3) cycle();
        do_reset();
        gnt_v    = 1'b0;
        inject_v = 1'b1;
        cycle();
        cycle();
        check("stray_rvalid_ignored", 32'(last_valid), 32'd0);
        grant_log.delete();
        gnt_v = 1'b1;
        lat_v = 1;
        repeat (4) cycle();
        v = (grant_log.size() != 0) ? grant_log[0] : 32'hxxxx_xxxx;
        check("restart_pc", v, RESET_PC);

        // Random traffic, then drain
        rnd_v = 1'b1;
        repeat (400) cycle();
        rnd_v = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
